alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Registered, multi-cycle execute unit. It sits directly downstream of the ALU control decoder and consumes its 4-bit ALUCtrl code plus the two register operands and shamt. Logic/arithmetic ops complete in one cycle. SLL/SRL/SRA use an iterative 1-bit-per-cycle shifter, which saves a barrel shifter. A valid/ready handshake on both sides lets the pipeline stall while a shift iterates.

Parameters:
WIDTH, 32, datapath width; the shift counter is $clog2(WIDTH) bits.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept (high only in IDLE)
alu_ctrl  input  4  ALU control code (alu_pkg encodings)
op_a  input  WIDTH  rs operand
op_b  input  WIDTH  rt operand; shift source for SLL/SRL/SRA
shamt  input  5  shift amount
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow; ADD/SUB only

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; overflow=0; shift counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, capture the operands and alu_ctrl.
  - Shift code with shamt!=0: load the shift register with op_b and the counter with shamt; go to SHIFT.
  - Any other case: compute the result and go to DONE next cycle. Latency is 1.
- SHIFT: each cycle, shift the register 1 bit and decrement the counter.
  - SLL: logical left, 0 in. SRL: logical right, 0 in. SRA: right, sign bit replicated.
  - When the counter reaches 1, that cycle's final shift is written to result and the FSM goes to DONE.
  - Latency from acceptance to out_valid is shamt cycles. shamt=0 goes directly to DONE with result=op_b (latency 1).
- DONE: out_valid=1; result, zero and overflow are held stable until out_ready=1. Then go to IDLE next cycle.
  - No new op is accepted in the same cycle. Maximum throughput is one op per 2 cycles.
- in_valid while not IDLE is ignored; the upstream stage holds its inputs because in_ready=0.
- Arithmetic, all WIDTH bits, wrap-around:
  - ADD/ADDU: a+b.
  - SUB/SUBU: a-b.
  - ADD: overflow = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
  - SUB: overflow = (a[msb]!=b[msb]) && (diff[msb]!=a[msb]).
  - ADDU/SUBU never flag overflow. Overflow only sets the flag; the result is still written.
- Logic: AND, OR, XOR, NOR(=~(a|b)).
- SLT: signed a<b gives 1, else 0. SLTU: unsigned compare.
- LUI: {b[15:0],16'h0}.
- Unlisted code: result=0, overflow=0, latency 1.
- zero is computed from the final result, for every op.
- rst asserted mid-SHIFT or in DONE: immediate return to reset values; the pending result is discarded.

Decomposition:
- alu_pkg holds:
  - ALU control code localparams: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7, ADDU=8, SUBU=9, XOR=10, SLTU=11, NOR=12, SRA=13, LUI=14.
  - An exec_state_t enum (IDLE, SHIFT, DONE).
  - The ALU control decoder shares this package.
- One sub-module is natural: alu_comb_core, the combinational single-cycle ops plus the overflow logic. The FSM, shift register and handshake stay in the top.

Test Plan:
1. Reset then ADD a=0x7FFFFFFF b=0x00000001 -> one cycle after accept: out_valid=1, result=0x80000000, overflow=1, zero=0. The same operands with ADDU -> overflow=0.
2. SUB a=5 b=5 -> result=0, zero=1, overflow=0. SLT a=0xFFFFFFFF b=1 -> 1. SLTU with the same operands -> 0.
3. SRA b=0x80000000 shamt=4 -> out_valid exactly 4 cycles after accept, result=0xF8000000. in_ready=0 throughout; a new in_valid during this time is ignored.
4. SLL b=0x00000001 shamt=31 -> result=0x80000000 after 31 cycles. SRL shamt=0 b=0x1234 -> result=0x1234, latency 1.
5. LUI b=0x0000ABCD -> 0xABCD0000. out_ready held low 3 cycles -> result and out_valid stable, then IDLE one cycle after the handshake.
6. Assert rst mid-SHIFT (SLL shamt=20, after 5 cycles) -> asynchronously out_valid=0, result=0, zero=1, in_ready=1. Next op: AND 0xF0F0 & 0x0FF0 -> 0x00F0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and execute-unit state type; the upstream
// ALU control decoder imports the same package.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_ADDU = 4'd8;
  localparam logic [3:0] ALU_SUBU = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_LUI  = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  function automatic logic is_shift(input logic [3:0] c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops and signed overflow detection. Shift codes return b
// unshifted, which is the zero-amount shift result.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam int M = WIDTH - 1;

  logic [WIDTH-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (alu_ctrl)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_ADD: begin
        res = sum;
        ovf = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      ALU_ADDU: res = sum;
      ALU_SUB: begin
        res = diff;
        ovf = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      ALU_SUBU: res = diff;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_LUI:  res = WIDTH'({b[15:0], 16'h0000});
      ALU_SLL, ALU_SRL, ALU_SRA: res = b;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute unit: single-cycle ALU ops, iterative 1-bit/cycle
// shifter, valid/ready on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  exec_state_t      state, nxt;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] core_res, first, step;
  logic             core_ovf, start_shift;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] c,
                                              input logic [WIDTH-1:0] x);
    case (c)
      ALU_SLL: return {x[WIDTH-2:0], 1'b0};
      ALU_SRA: return {x[WIDTH-1], x[WIDTH-1:1]};
      default: return {1'b0, x[WIDTH-1:1]};
    endcase
  endfunction

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctrl (alu_ctrl),
    .a        (op_a),
    .b        (op_b),
    .res      (core_res),
    .ovf      (core_ovf)
  );

  // The first shift step happens in the accept cycle, so out_valid rises
  // exactly shamt cycles after acceptance.
  assign start_shift = is_shift(alu_ctrl) && (shamt != 5'd0);
  assign first       = shift1(alu_ctrl, op_b);
  assign step        = shift1(ctrl_q, shreg);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero      = (result == '0);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = (start_shift && shamt != 5'd1) ? SHIFT : DONE;
      SHIFT:   if (cnt == CW'(1)) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctrl_q   <= '0;
      shreg    <= '0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          ctrl_q <= alu_ctrl;
          if (start_shift) begin
            shreg    <= first;
            cnt      <= CW'(shamt - 5'd1);
            overflow <= 1'b0;
            if (shamt == 5'd1) result <= first;
          end else begin
            result   <= core_res;
            overflow <= core_ovf;
          end
        end
        SHIFT: begin
          shreg <= step;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) result <= step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus hand sequences for
// shift timing, back-pressure and mid-shift reset.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, zero, overflow;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b, result;
  logic [4:0]   shamt;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s);
    alu_ctrl = c; op_a = a; op_b = b; shamt = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1};
    vecs[1]  = '{ALU_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1};
    vecs[2]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1};
    vecs[3]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1};
    vecs[4]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1};
    vecs[5]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1};
    vecs[6]  = '{ALU_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFE, 1'b0, 1};
    vecs[7]  = '{ALU_SUBU, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0, 1};
    vecs[8]  = '{ALU_AND,  32'h0000F0F0, 32'h00000FF0, 5'd0,  32'h000000F0, 1'b0, 1};
    vecs[9]  = '{ALU_OR,   32'h0000F0F0, 32'h00000FF0, 5'd0,  32'h0000FFF0, 1'b0, 1};
    vecs[10] = '{ALU_XOR,  32'h0000F0F0, 32'h00000FF0, 5'd0,  32'h0000FF00, 1'b0, 1};
    vecs[11] = '{ALU_NOR,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1};
    vecs[12] = '{ALU_LUI,  32'h00000000, 32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0, 1};
    vecs[13] = '{4'd5,     32'h00000001, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1};
    vecs[14] = '{ALU_SRL,  32'h00000000, 32'h00001234, 5'd0,  32'h00001234, 1'b0, 1};
    vecs[15] = '{ALU_SLL,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 31};
    vecs[16] = '{ALU_SRL,  32'h00000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0, 1};
    vecs[17] = '{ALU_SRA,  32'h00000000, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0, 31};
    vecs[18] = '{ALU_SRL,  32'h00000000, 32'hF0000000, 5'd8,  32'h00F00000, 1'b0, 8};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result",    result,    0);
    chk("rst_zero",      zero,      1);
    chk("rst_overflow",  overflow,  0);

    for (int i = 0; i < 19; i++) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), W'(lat), W'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), result, vecs[i].res);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].res == 0);
      retire();
      chk($sformatf("v%0d_idle", i), in_ready, 1);
    end

    // SRA by 4 with a competing request held on the input the whole time
    issue(ALU_SRA, 32'h0, 32'h80000000, 5'd4);
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk("sra_busy_in_ready", in_ready, 0);
      alu_ctrl = ALU_ADD; op_a = 32'h1; op_b = 32'h2; shamt = 5'd0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("sra_done_in_ready", in_ready, 0);
    in_valid = 1'b0;
    chk("sra_lat", W'(lat), W'(4));
    chk("sra_res", result, 32'hF8000000);
    retire();
    chk("sra_no_extra_op", out_valid, 0);

    // Back-pressure: result must hold while out_ready stays low
    issue(ALU_LUI, 32'h0, 32'h0000ABCD, 5'd0);
    wait_done(lat);
    repeat (3) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_res", result, 32'hABCD0000);
      @(posedge clk); #1;
    end
    retire();
    chk("hold_idle_ready", in_ready, 1);
    chk("hold_idle_valid", out_valid, 0);

    // Asynchronous reset in the middle of a long shift
    issue(ALU_SLL, 32'h0, 32'h00000001, 5'd20);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_result",    result,    0);
    chk("arst_zero",      zero,      1);
    chk("arst_in_ready",  in_ready,  1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(ALU_AND, 32'h0000F0F0, 32'h00000FF0, 5'd0);
    wait_done(lat);
    chk("post_rst_lat", W'(lat), W'(1));
    chk("post_rst_res", result, 32'h000000F0);
    retire();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
